bch_seq_decoder: RTL and testbench
==================================

BCH_SEQ_DECODER -- requirements
Module: bch_seq_decoder

Interface
REQ-001 SHALL have parameter N, default 15, meaning codeword length in bits.
REQ-002 SHALL have parameter K, default 5, meaning data length in bits; N-K is the parity width.
REQ-003 SHALL have parameter GEN [N-K:0], default 11'b10100110111, meaning generator polynomial with MSB = x^(N-K).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: codeword_in is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: decoder can accept a codeword.
REQ-008 SHALL have port codeword_in, input, N bits: received word; bit N-1 is the highest-order coefficient, bits [N-1:N-K] are data.
REQ-009 SHALL have port out_valid, output, 1 bit: result fields are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port data_out, output, K bits: corrected_codeword[N-1:N-K].
REQ-012 SHALL have port corrected_codeword, output, N bits.
REQ-013 SHALL have port syndrome, output, N-K bits: remainder of codeword_in mod GEN.
REQ-014 SHALL have port error_detected, output, 1 bit: syndrome nonzero.
REQ-015 SHALL have port error_corrected, output, 1 bit: a correcting pattern was found.
REQ-016 SHALL have port uncorrectable, output, 1 bit: error detected, no pattern found.
REQ-017 SHALL have port err_count, output, 2 bits: number of bits flipped (0, 1 or 2).

Function
REQ-018 SHALL implement FSM states IDLE, SYND, SEARCH1, SEARCH2, DONE.
REQ-019 SHALL assert in_ready only in IDLE; transfer occurs when in_valid && in_ready; the codeword is captured and the FSM enters SYND.
REQ-020 In SYND, SHALL shift one bit per cycle, MSB first, through a GEN-reducing LFSR, taking exactly N cycles.
REQ-021 If the syndrome is zero, SHALL enter DONE with corrected_codeword = codeword_in, err_count 0 and all flags 0; out_valid rises N+1 cycles after acceptance.
REQ-022 If the syndrome is nonzero, SHALL enter SEARCH1; cycle m (m = 0..N-1) compares r_m = x^m mod GEN against the syndrome and stores r_m in a table of N entries.
REQ-023 On the first SEARCH1 hit at index p, SHALL flip bit p, set error_corrected and err_count 1, and enter DONE; out_valid rises N+2+p cycles after acceptance.
REQ-024 SEARCH2 SHALL test one pair (i,j), i<j, per cycle in lexicographic order, checking r_i ^ r_j == syndrome; the first hit flips bits i and j, sets err_count 2 and enters DONE.
REQ-025 If no pattern matches, SHALL enter DONE with uncorrectable=1, corrected_codeword = codeword_in and err_count 0.
REQ-026 error_detected SHALL equal (syndrome != 0) in DONE; error_corrected and uncorrectable SHALL be mutually exclusive.
REQ-027 In DONE, SHALL hold out_valid and all result fields stable until out_ready; on out_valid && out_ready, SHALL return to IDLE.
REQ-028 SHALL assert in_ready no earlier than the cycle after the result handshake; there is no pipelining of a second codeword.
REQ-029 Worst-case latency SHALL be 2N+N(N-1)/2+1 cycles from acceptance to out_valid.

Reset
REQ-030 With rst high at a clock edge, SHALL enter IDLE from any state, aborting work in progress, with no output of the aborted word.
REQ-031 Reset values: in_ready 0 during rst then 1 in IDLE, out_valid 0, all result fields 0.

Configuration
REQ-032 Macro BCH_DOUBLE_CORRECT_EN defined: SEARCH2 is present as specified above.
REQ-033 Macro BCH_DOUBLE_CORRECT_EN undefined: SEARCH2 and the r_m table are removed, a SEARCH1 miss goes directly to DONE with uncorrectable=1, and worst-case latency is 2N+1.

Structure
REQ-034 Package bch_pkg SHALL hold the FSM state enum typedef and the default GEN constant for (15,5).
REQ-035 SHALL instantiate one sub-module, bch_rem_lfsr (serial shift/reduce by GEN), used for the syndrome computation and for the r_m generation.

Verification
REQ-036 Input all-zero codeword -> syndrome 0, err_count 0, out_valid at acceptance+16.
REQ-037 Input 15'h0008 (bit 3 set) -> syndrome 10'h008, corrected 0, err_count 1, out_valid at acceptance+20.
REQ-038 bch_encoder_15_5(5'b10110) with bits 2 and 12 flipped -> data_out 5'b10110, err_count 2, error_corrected 1.
REQ-039 Input with 3 flipped bits whose syndrome matches no 1- or 2-bit pattern -> uncorrectable 1, corrected_codeword = input.
REQ-040 out_ready held low for 5 cycles in DONE -> outputs stable, in_ready 0; rst asserted during SEARCH2 -> IDLE next cycle, out_valid 0.
REQ-041 Compiled without BCH_DOUBLE_CORRECT_EN, the 2-bit case of REQ-038 -> uncorrectable 1 at acceptance+31.

Source files
------------

// File: rtl/bch_pkg.sv
// rtl/bch_pkg.sv - shared FSM state type and default generator for the (15,5) BCH decoder
package bch_pkg;

  // Decoder sequencing states
  typedef enum logic [2:0] {
    IDLE,
    SYND,
    SEARCH1,
    SEARCH2,
    DONE
  } state_t;

  // Generator x^10+x^8+x^5+x^4+x^2+x+1 of the triple-error-correcting (15,5) BCH code
  localparam logic [10:0] BCH15_5_GEN = 11'b10100110111;

endpackage

// File: rtl/bch_rem_lfsr.sv
// rtl/bch_rem_lfsr.sv - serial shift-and-reduce register computing a polynomial remainder mod POLY
module bch_rem_lfsr #(
  parameter int W = 10,
  parameter logic [W:0] POLY = 11'b10100110111
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         shift,
  input  logic         bit_in,
  output logic [W-1:0] rem
);

  // rem <= (rem * x + bit_in) mod POLY on each shift; load seeds the register
  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= '0;
    end else if (load) begin
      rem <= load_value;
    end else if (shift) begin
      rem <= {rem[W-2:0], bit_in} ^ (rem[W-1] ? POLY[W-1:0] : '0);
    end
  end

endmodule

// File: rtl/bch_seq_decoder.sv
// rtl/bch_seq_decoder.sv - sequential BCH decoder; BCH_DOUBLE_CORRECT_EN adds the two-bit pair search
module bch_seq_decoder
  import bch_pkg::*;
#(
  parameter int N = 15,
  parameter int K = 5,
  parameter logic [N-K:0] GEN = BCH15_5_GEN
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   codeword_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [K-1:0]   data_out,
  output logic [N-1:0]   corrected_codeword,
  output logic [N-K-1:0] syndrome,
  output logic           error_detected,
  output logic           error_corrected,
  output logic           uncorrectable,
  output logic [1:0]     err_count
);

  localparam int P  = N - K;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] SYND_LAST = CW'(N);
  localparam logic [CW-1:0] POS_LAST  = CW'(N - 1);
  localparam logic [N-1:0]  UNIT_N    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [P-1:0]  UNIT_P    = {{(P-1){1'b0}}, 1'b1};

  state_t         state_q, state_d;
  logic [N-1:0]   cw_q, sh_q, corr_q;
  logic [CW-1:0]  cnt_q;
  logic [P-1:0]   syn_q;
  logic           ec_q, unc_q;
  logic [1:0]     errc_q;

  logic           lfsr_load, lfsr_shift, lfsr_bit;
  logic [P-1:0]   lfsr_load_value;
  logic [P-1:0]   rem;
  logic           synd_done, hit1;

  bch_rem_lfsr #(.W(P), .POLY(GEN)) u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .load       (lfsr_load),
    .load_value (lfsr_load_value),
    .shift      (lfsr_shift),
    .bit_in     (lfsr_bit),
    .rem        (rem)
  );

  // After N shifts the remainder register holds the syndrome; in SEARCH1 it walks x^m mod GEN
  assign synd_done = (cnt_q == SYND_LAST);
  assign hit1      = (rem == syn_q);

`ifdef BCH_DOUBLE_CORRECT_EN
  localparam logic [CW-1:0] PAIR_I_LAST = CW'(N - 2);
  logic [P-1:0]  tbl [N];
  logic [CW-1:0] i_q, j_q;
  logic          hit2, pair_last;

  assign hit2      = ((tbl[i_q] ^ tbl[j_q]) == syn_q);
  assign pair_last = (i_q == PAIR_I_LAST) && (j_q == POS_LAST);

  // Keep every single-bit syndrome r_m so the pair search can combine any two of them
  always_ff @(posedge clk) begin
    if (state_q == SEARCH1) begin
      tbl[cnt_q] <= rem;
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and remainder-register control
  always_comb begin
    state_d         = state_q;
    lfsr_load       = 1'b0;
    lfsr_load_value = '0;
    lfsr_shift      = 1'b0;
    lfsr_bit        = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d   = SYND;
          lfsr_load = 1'b1;
        end
      end
      SYND: begin
        if (synd_done) begin
          if (rem == '0) begin
            state_d = DONE;
          end else begin
            state_d         = SEARCH1;
            lfsr_load       = 1'b1;
            lfsr_load_value = UNIT_P;
          end
        end else begin
          lfsr_shift = 1'b1;
          lfsr_bit   = sh_q[N-1];
        end
      end
      SEARCH1: begin
        lfsr_shift = 1'b1;
        if (hit1) begin
          state_d = DONE;
        end else if (cnt_q == POS_LAST) begin
`ifdef BCH_DOUBLE_CORRECT_EN
          state_d = SEARCH2;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef BCH_DOUBLE_CORRECT_EN
      SEARCH2: begin
        if (hit2 || pair_last) begin
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture word, count steps, record the correction result
  always_ff @(posedge clk) begin
    if (rst) begin
      cw_q   <= '0;
      sh_q   <= '0;
      cnt_q  <= '0;
      syn_q  <= '0;
      corr_q <= '0;
      ec_q   <= 1'b0;
      unc_q  <= 1'b0;
      errc_q <= 2'd0;
`ifdef BCH_DOUBLE_CORRECT_EN
      i_q    <= '0;
      j_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            cw_q  <= codeword_in;
            sh_q  <= codeword_in;
            cnt_q <= '0;
          end
        end
        SYND: begin
          if (synd_done) begin
            syn_q  <= rem;
            cnt_q  <= '0;
            corr_q <= cw_q;
            ec_q   <= 1'b0;
            unc_q  <= 1'b0;
            errc_q <= 2'd0;
          end else begin
            sh_q  <= sh_q << 1;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        SEARCH1: begin
          cnt_q <= cnt_q + CW'(1);
          if (hit1) begin
            corr_q <= cw_q ^ (UNIT_N << cnt_q);
            ec_q   <= 1'b1;
            errc_q <= 2'd1;
          end else if (cnt_q == POS_LAST) begin
`ifdef BCH_DOUBLE_CORRECT_EN
            i_q <= '0;
            j_q <= CW'(1);
`else
            unc_q <= 1'b1;
`endif
          end
        end
`ifdef BCH_DOUBLE_CORRECT_EN
        SEARCH2: begin
          if (hit2) begin
            corr_q <= cw_q ^ (UNIT_N << i_q) ^ (UNIT_N << j_q);
            ec_q   <= 1'b1;
            errc_q <= 2'd2;
          end else if (pair_last) begin
            unc_q <= 1'b1;
          end else if (j_q == POS_LAST) begin
            i_q <= i_q + CW'(1);
            j_q <= i_q + CW'(2);
          end else begin
            j_q <= j_q + CW'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign in_ready           = (state_q == IDLE) && !rst;
  assign out_valid          = (state_q == DONE);
  assign corrected_codeword = corr_q;
  assign data_out           = corr_q[N-1:N-K];
  assign syndrome           = syn_q;
  assign error_detected     = |syn_q;
  assign error_corrected    = ec_q;
  assign uncorrectable      = unc_q;
  assign err_count          = errc_q;

endmodule

// File: tb/tb_bch_seq_decoder.sv
// tb/tb_bch_seq_decoder.sv - directed self-checking bench for bch_seq_decoder
module tb_bch_seq_decoder;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [14:0] codeword_in, corrected_codeword;
  logic [4:0]  data_out;
  logic [9:0]  syndrome;
  logic        error_detected, error_corrected, uncorrectable;
  logic [1:0]  err_count;

  int errors = 0;
  int checks = 0;

`ifdef BCH_DOUBLE_CORRECT_EN
  localparam int LAT_UNC   = 136;
  localparam int ABORT_AT  = 40;
`else
  localparam int LAT_UNC   = 31;
  localparam int ABORT_AT  = 24;
`endif

  always #5 clk = ~clk;

  bch_seq_decoder dut (
    .clk                (clk),
    .rst                (rst),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .codeword_in        (codeword_in),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .data_out           (data_out),
    .corrected_codeword (corrected_codeword),
    .syndrome           (syndrome),
    .error_detected     (error_detected),
    .error_corrected    (error_corrected),
    .uncorrectable      (uncorrectable),
    .err_count          (err_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [14:0] cw);
    int t = 0;
    while (in_ready !== 1'b1 && t < 20) begin
      step();
      t++;
    end
    codeword_in = cw;
    in_valid    = 1'b1;
    step();
    in_valid    = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 300) begin
      step();
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; codeword_in = '0;
    step(); step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if ({corrected_codeword, syndrome, err_count, error_detected, error_corrected, uncorrectable} !== '0) begin
      errors++; $display("FAIL reset_fields: cw=%h syn=%h cnt=%0d flags=%b%b%b want all 0",
                         corrected_codeword, syndrome, err_count, error_detected, error_corrected, uncorrectable);
    end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_idle_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_zero_word();
    int lat;
    accept(15'h0000);
    wait_result(lat);
    checks++; if (lat !== 16) begin errors++; $display("FAIL zero_latency: got %0d want 16", lat); end
    checks++; if (syndrome !== 10'h000 || err_count !== 2'd0) begin errors++; $display("FAIL zero_syn: syn=%h cnt=%0d want 000/0", syndrome, err_count); end
    checks++; if ({error_detected, error_corrected, uncorrectable} !== 3'b000 || corrected_codeword !== 15'h0000) begin
      errors++; $display("FAIL zero_flags: flags=%b cw=%h want 000/0000", {error_detected, error_corrected, uncorrectable}, corrected_codeword);
    end
    release_result();
  endtask

  task automatic test_single_bit3();
    int lat;
    accept(15'h0008);
    wait_result(lat);
    checks++; if (lat !== 20) begin errors++; $display("FAIL single3_latency: got %0d want 20", lat); end
    checks++; if (syndrome !== 10'h008) begin errors++; $display("FAIL single3_syn: got %h want 008", syndrome); end
    checks++; if (corrected_codeword !== 15'h0000 || err_count !== 2'd1) begin errors++; $display("FAIL single3_fix: cw=%h cnt=%0d want 0000/1", corrected_codeword, err_count); end
    checks++; if ({error_detected, error_corrected, uncorrectable} !== 3'b110) begin errors++; $display("FAIL single3_flags: got %b want 110", {error_detected, error_corrected, uncorrectable}); end
    release_result();
  endtask

  task automatic test_single_bit14();
    int lat;
    accept(15'h191E);
    wait_result(lat);
    checks++; if (lat !== 31) begin errors++; $display("FAIL single14_latency: got %0d want 31", lat); end
    checks++; if (syndrome !== 10'h29B) begin errors++; $display("FAIL single14_syn: got %h want 29b", syndrome); end
    checks++; if (corrected_codeword !== 15'h591E || data_out !== 5'b10110 || err_count !== 2'd1) begin
      errors++; $display("FAIL single14_fix: cw=%h data=%b cnt=%0d want 591e/10110/1", corrected_codeword, data_out, err_count);
    end
    release_result();
  endtask

  task automatic test_double();
    int lat;
    accept(15'h491A);
    wait_result(lat);
    checks++; if (syndrome !== 10'h1EF) begin errors++; $display("FAIL double_syn: got %h want 1ef", syndrome); end
`ifdef BCH_DOUBLE_CORRECT_EN
    checks++; if (lat !== 68) begin errors++; $display("FAIL double_latency: got %0d want 68", lat); end
    checks++; if (data_out !== 5'b10110 || corrected_codeword !== 15'h591E || err_count !== 2'd2) begin
      errors++; $display("FAIL double_fix: data=%b cw=%h cnt=%0d want 10110/591e/2", data_out, corrected_codeword, err_count);
    end
    checks++; if ({error_detected, error_corrected, uncorrectable} !== 3'b110) begin errors++; $display("FAIL double_flags: got %b want 110", {error_detected, error_corrected, uncorrectable}); end
`else
    checks++; if (lat !== 31) begin errors++; $display("FAIL double_latency: got %0d want 31", lat); end
    checks++; if (corrected_codeword !== 15'h491A || err_count !== 2'd0) begin errors++; $display("FAIL double_fix: cw=%h cnt=%0d want 491a/0", corrected_codeword, err_count); end
    checks++; if ({error_detected, error_corrected, uncorrectable} !== 3'b101) begin errors++; $display("FAIL double_flags: got %b want 101", {error_detected, error_corrected, uncorrectable}); end
`endif
    release_result();
  endtask

  task automatic test_uncorrectable();
    int lat;
    accept(15'h0007);
    wait_result(lat);
    checks++; if (lat !== LAT_UNC) begin errors++; $display("FAIL unc_latency: got %0d want %0d", lat, LAT_UNC); end
    checks++; if (syndrome !== 10'h007 || corrected_codeword !== 15'h0007 || err_count !== 2'd0) begin
      errors++; $display("FAIL unc_fields: syn=%h cw=%h cnt=%0d want 007/0007/0", syndrome, corrected_codeword, err_count);
    end
    checks++; if ({error_detected, error_corrected, uncorrectable} !== 3'b101) begin errors++; $display("FAIL unc_flags: got %b want 101", {error_detected, error_corrected, uncorrectable}); end
    release_result();
  endtask

  task automatic test_backpressure();
    int lat;
    accept(15'h0008);
    wait_result(lat);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || corrected_codeword !== 15'h0000 || syndrome !== 10'h008 || err_count !== 2'd1) begin
        errors++; $display("FAIL hold_cycle%0d: ov=%b ir=%b cw=%h syn=%h cnt=%0d want 1/0/0000/008/1",
                           c, out_valid, in_ready, corrected_codeword, syndrome, err_count);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_handshake_ready: got %b want 0", in_ready); end
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_release: ov=%b ir=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_abort();
    int lat;
    int seen = 0;
    accept(15'h0007);
    for (int c = 1; c < ABORT_AT; c++) step();
    rst = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL abort_in_reset: ov=%b ir=%b want 0/0", out_valid, in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_idle: in_ready=%b want 1", in_ready); end
    for (int c = 0; c < 150; c++) begin
      if (out_valid === 1'b1) seen++;
      step();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_output: out_valid seen %0d cycles want 0", seen); end
    accept(15'h0000);
    wait_result(lat);
    checks++; if (lat !== 16 || syndrome !== 10'h000) begin errors++; $display("FAIL abort_recover: lat=%0d syn=%h want 16/000", lat, syndrome); end
    release_result();
  endtask

  initial begin
    test_reset();
    test_zero_word();
    test_single_bit3();
    test_single_bit14();
    test_double();
    test_uncorrectable();
    test_backpressure();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
